timer_scheduler: RTL

Sequencer/arbiter that shares the single BAMSE timer among `N_REQ` requesters. It accepts one-shot delay requests (16-bit load value plus 3-bit prescaler), grants them round-robin and programs the timer through its 8-bit register bus. It then waits for the timer interrupt, clears and disables the timer, and returns a one-cycle `done` pulse to the granted requester. It sits between the requesting peripherals and the timer, owning the timer's `timer_conf`, `address`, `config_in` and `wen` inputs.

---
 rtl/timer_scheduler_if.sv | 35 +++
 rtl/timer_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler_if.sv
// timer_scheduler_if: bundles the requester handshake and the timer register bus of
// timer_scheduler.
//   master modport: scheduler side (drives gnt/done/err/busy and the timer bus).
//   slave modport : environment side (requesters plus the timer).
//   req/req_load/req_ps : per-requester level request, 16-bit load, 3-bit prescaler
//   gnt/done/err        : one-hot grant, completion pulse, watchdog abort pulse
//   busy                : scheduler not idle
//   tmr_load/tmr_addr/tmr_wdata/tmr_wen : timer register bus
//   tmr_irq             : timer interrupt level
interface timer_scheduler_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_load;
  logic [3*N_REQ-1:0]  req_ps;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic [N_REQ-1:0]    err;
  logic                busy;
  logic [15:0]         tmr_load;
  logic [7:0]          tmr_addr;
  logic [7:0]          tmr_wdata;
  logic                tmr_wen;
  logic                tmr_irq;

  modport master (
    input  req, req_load, req_ps, tmr_irq,
    output gnt, done, err, busy, tmr_load, tmr_addr, tmr_wdata, tmr_wen
  );

  modport slave (
    output req, req_load, req_ps, tmr_irq,
    input  gnt, done, err, busy, tmr_load, tmr_addr, tmr_wdata, tmr_wen
  );
endinterface

// File: rtl/timer_scheduler.sv
// timer_scheduler: shares one timer among N_REQ requesters. Grants one-shot delay
// requests round-robin, programs the timer (enable, then GO), waits for a fresh rising
// edge of the timer interrupt, clears/disables the timer and pulses done to the
// granted requester. All outputs are registered.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : timer_scheduler_if.master (requester handshake + timer register bus)
// Optional feature: define TIMER_SCHED_WDOG_EN to abort a WAIT lasting WDOG_LIMIT
// cycles with an err pulse; otherwise err is constant 0 and WAIT is unbounded.
module timer_scheduler #(
  parameter int unsigned N_REQ      = 4,
  parameter logic [7:0]  TMR_ADDR   = 8'h00,
  parameter logic [23:0] WDOG_LIMIT = 24'hFFFFFF
) (
  input logic                clk,
  input logic                rst,
  timer_scheduler_if.master  bus
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  typedef enum logic [2:0] {StIdle, StCfg, StStart, StWait, StClr} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;  // last granted requester, also the active grant
  logic [2:0]        ps_q, ps_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic              busy_q, busy_d;
  logic [15:0]       load_q, load_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic [7:0]        addr_q;
  logic              irq_q;

  logic              sel_found;
  logic [IdxW-1:0]   sel_idx;
  logic [31:0]       cand;
  logic [2:0]        sel_ps;
  logic              irq_rise;
  logic              wdog_hit;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(ptr_q) + k) % N_REQ;
      if (!sel_found && bus.req[cand[IdxW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IdxW-1:0];
      end
    end
  end

  assign sel_ps   = bus.req_ps[3*sel_idx +: 3];
  // A level already high when WAIT is entered is not an edge: irq_q tracks every cycle.
  assign irq_rise = bus.tmr_irq & ~irq_q;

`ifdef TIMER_SCHED_WDOG_EN
  logic [23:0] wdog_q, wdog_d;

  // Held at zero outside WAIT, so it is clear on every WAIT entry.
  always_comb begin
    wdog_d = '0;
    if (state_q == StWait) wdog_d = wdog_q + 24'd1;
  end

  assign wdog_hit = (state_q == StWait) && (wdog_q == WDOG_LIMIT - 24'd1);

  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_LIMIT;
  assign wdog_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ps_d    = ps_q;
    gnt_d   = gnt_q;
    load_d  = load_q;
    wdata_d = wdata_q;
    done_d  = '0;
    err_d   = '0;
    wen_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d = StCfg;
          ptr_d   = sel_idx;
          ps_d    = sel_ps;
          load_d  = bus.req_load[16*sel_idx +: 16];
          gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
          wen_d   = 1'b1;
          wdata_d = {1'b0, sel_ps, 4'b0100};  // EN, INT cleared
        end
      end
      StCfg, StStart, StWait: begin
        if (!bus.req[ptr_q]) begin
          // Requester abort: disable the timer, no pulse.
          state_d = StClr;
          wen_d   = 1'b1;
          wdata_d = 8'h00;
        end else if (state_q == StCfg) begin
          state_d = StStart;
          wen_d   = 1'b1;
          wdata_d = {1'b0, ps_q, 4'b0110};    // EN + GO
        end else if (state_q == StStart) begin
          state_d = StWait;
        end else if (irq_rise) begin
          state_d       = StClr;
          wen_d         = 1'b1;
          wdata_d       = 8'h00;
          done_d[ptr_q] = 1'b1;
        end else if (wdog_hit) begin
          state_d      = StClr;
          wen_d        = 1'b1;
          wdata_d      = 8'h00;
          err_d[ptr_q] = 1'b1;
        end
      end
      StClr: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= IdxW'(N_REQ - 1);
      ps_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      load_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      addr_q  <= TMR_ADDR;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ps_q    <= ps_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      addr_q  <= TMR_ADDR;
      irq_q   <= bus.tmr_irq;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;
  assign bus.tmr_load  = load_q;
  assign bus.tmr_addr  = addr_q;
  assign bus.tmr_wdata = wdata_q;
  assign bus.tmr_wen   = wen_q;

endmodule
